// File: rtl/vec_dispatch_pkg.sv
// Shared types and constants for the vector instruction dispatch queue.
package vec_dispatch_pkg;

  localparam int         DISPATCH_XLEN = 32;
  localparam logic [6:0] VLOAD_OPCODE  = 7'b0000111;

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_LD = 1'b1
  } dispatch_state_e;

  typedef struct packed {
    logic [DISPATCH_XLEN-1:0] inst;
    logic [DISPATCH_XLEN-1:0] rs1;
    logic [DISPATCH_XLEN-1:0] rs2;
  } dispatch_entry_t;

  // True when the opcode field identifies a vector load.
  function automatic logic is_vload(input logic [6:0] opcode);
    return opcode == VLOAD_OPCODE;
  endfunction

endpackage

// File: rtl/vec_dispatch_fifo.sv
// Generic DEPTH x WIDTH circular buffer with push/pop and an occupancy count.
// Storage is not reset; only the pointers and count are.
module vec_dispatch_fifo
  import vec_dispatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next-state pointers and count; pointers wrap naturally as DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/vec_inst_dispatch_queue.sv
// Dispatch FIFO between the scalar core and the vector datapath. Non-load
// heads retire in the cycle they are presented; a load head is held stable
// until is_loaded, or force-retired by a watchdog after LD_TIMEOUT cycles.
// XLEN must match the package entry width.
module vec_inst_dispatch_queue
  import vec_dispatch_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int XLEN       = 32,
  parameter int LD_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inst_valid,
  output logic                   inst_ready,
  input  logic [XLEN-1:0]        inst_in,
  input  logic [XLEN-1:0]        rs1_in,
  input  logic [XLEN-1:0]        rs2_in,
  output logic [XLEN-1:0]        instruction,
  output logic [XLEN-1:0]        rs1_data,
  output logic [XLEN-1:0]        rs2_data,
  output logic                   issue_valid,
  input  logic                   is_vec,
  input  logic                   is_loaded,
  output logic                   retire,
  output logic                   illegal_inst,
  output logic                   ld_timeout,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int TMO_W = $clog2(LD_TIMEOUT) + 1;

  dispatch_entry_t   wr_entry;
  dispatch_entry_t   head_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              force_retire;
  dispatch_state_e   state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  assign wr_entry = '{inst: inst_in, rs1: rs1_in, rs2: rs2_in};

  // Acceptance ignores a same-cycle pop so a full queue never takes a push.
  assign inst_ready = !fifo_full;
  assign push       = inst_valid && !fifo_full;

  vec_dispatch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(dispatch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head_entry),
    .count (occupancy),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head presentation: zeroed whenever the queue is empty.
  always_comb begin
    issue_valid = !fifo_empty;
    instruction = '0;
    rs1_data    = '0;
    rs2_data    = '0;
    if (!fifo_empty) begin
      instruction = head_entry.inst;
      rs1_data    = head_entry.rs1;
      rs2_data    = head_entry.rs2;
    end
  end

  // Dispatch FSM and load watchdog next-state logic.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    pop          = 1'b0;
    force_retire = 1'b0;
    unique case (state_q)
      RUN: begin
        if (!fifo_empty) begin
          if (is_vload(head_entry.inst[6:0])) begin
            state_d = WAIT_LD;
            tmo_d   = '0;
          end else begin
            pop = 1'b1;
          end
        end
      end
      WAIT_LD: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (is_loaded) begin
          pop     = 1'b1;
          state_d = RUN;
        end else if (tmo_q == TMO_W'(LD_TIMEOUT - 1)) begin
          pop          = 1'b1;
          force_retire = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Reset dominates: no retire-side pulse leaves the block in a reset cycle.
  assign retire       = pop && !reset;
  assign illegal_inst = retire && !is_vec;
  assign ld_timeout   = force_retire && !reset;

  // FSM state and watchdog counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
